ram_128x16_bist_ctrl: RTL and testbench
=======================================

// Module: ram_128x16_bist_ctrl
// PURPOSE
//  - March C- built-in self-test sequencer for the 128x16 RAM wrapper.
//  - Owns the RAM port (a/din/wr/oe/test_mode) during a run; the functional path reconnects via an external mux on 'busy'.
//  - Reports pass/fail and the first failing location to test control logic.
// PARAMETERS
//  ADDR_W   7        RAM address width (words = 2**ADDR_W)
//  DATA_W   16       RAM data width
//  BG_DATA  16'h0000 data background; "0" = BG_DATA, "1" = ~BG_DATA
// PORTS
//  clk           in   1       single clock; all state on rising edge
//  reset         in   1       synchronous, active-high
//  start         in   1       begin run; sampled only in IDLE/DONE
//  busy          out  1       run in progress (owns RAM port)
//  done          out  1       run finished; held until next start or reset
//  fail          out  1       sticky miscompare flag, valid while done=1
//  fail_addr     out  ADDR_W  address of first miscompare
//  fail_elem     out  3       March element (0..5) of first miscompare
//  fail_data     out  DATA_W  read data at first miscompare
//  ram_a         out  ADDR_W  RAM address
//  ram_din       out  DATA_W  RAM write data
//  ram_wr        out  1       write strobe, one-cycle pulse per write op
//  ram_oe        out  1       output enable, high on read-op cycles
//  ram_test_mode out  1       held 0 while busy (no bypass of array)
//  ram_dout      in   DATA_W  RAM read data, valid 1 cycle after read op
// BEHAVIOUR
//  - Reset: state=IDLE; busy=done=fail=0; fail_addr/elem/data=0; ram_a=0, ram_din=0, ram_wr=ram_oe=ram_test_mode=0. Reset mid-run aborts immediately; no further RAM ops.
//  - FSM: IDLE -start-> RUN -last op-> FLUSH -> DONE -start-> RUN. start ignored in RUN/FLUSH.
//  - Elements: E0 up(w0); E1 up(r0,w1); E2 up(r1,w0); E3 down(r0,w1); E4 down(r1,w0); E5 up(r0).
//  - One op per cycle, no idle cycles between ops or elements: 10*128 = 1280 op cycles.
//  - Address counter: up elements 0->127, down elements 127->0. Element advances when the counter reaches its terminal value, after the last op at that address; counter reloads (0 or 127) for the next element.
//  - Read op: ram_oe=1, ram_wr=0. Expected value is registered; ram_dout is compared on the next cycle (pipeline depth 1).
//  - Write op: ram_wr=1, ram_oe=0, ram_din=pattern.
//  - FLUSH: one cycle for the final E5 compare, no RAM op. Then DONE: busy=0, done=1.
//  - Timing: start seen at edge k -> busy=1 and first op in cycle k+1; last op in cycle k+1280; done=1 from cycle k+1282.
//  - First miscompare latches fail=1, fail_addr/fail_elem/fail_data. Later miscompares do not overwrite them.
//  - start in DONE clears done, fail and fail_* in the same edge that enters RUN.
//  - Outside RUN: ram_wr=ram_oe=0.
// CONFIGURATION
//  BIST_STOP_ON_FAIL_EN defined: the first miscompare ends the run. No further RAM ops; next cycle enters DONE with fail=1. The pipelined op already issued is discarded.
//  Not defined: the run always completes all 1280 ops. Only the first failure is captured; fail is sticky.
// TESTING
//  1 Good RAM model, pulse start at cycle 0 -> busy cycles 1..1281; done=1 at cycle 1282; fail=0; 640 ram_wr pulses, 640 ram_oe cycles.
//  2 Stuck-at-1 on bit 3 @ addr 7'h05 -> fail=1, fail_addr=5, fail_elem=1, fail_data=16'h0008.
//  3 Coupling fault (write addr 0x10 flips addr 0x11) -> fail=1, fail_addr=0x11; with STOP_ON_FAIL_EN, done asserts within 2 cycles of the miscompare.
//  4 Assert reset at cycle 500 of a run -> next cycle busy=0, ram_wr=ram_oe=0, done=0; fresh start then reruns a full 1280-op sequence.
//  5 Hold start high through a run -> no restart while busy; restarts on the first DONE cycle, done and fail cleared.
//  6 Check the address trace -> E3 first op at a=127 and last at a=0; E4 ends at a=0; E5 starts at a=0.

Source files
------------

// File: rtl/ram_128x16_bist_ctrl.sv
// ram_128x16_bist_ctrl -- March C- self-test sequencer for the 128x16 RAM wrapper.
// Drives the RAM port while busy_o is high and reports the first miscompare.
// Build option: define BIST_STOP_ON_FAIL_EN to end the run on the first miscompare;
// without it every run issues all 10*2**ADDR_W operations.
module ram_128x16_bist_ctrl #(
  parameter int                  ADDR_W  = 7,
  parameter int                  DATA_W  = 16,
  parameter logic [DATA_W-1:0]   BG_DATA = 16'h0000
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              start_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              fail_o,
  output logic [ADDR_W-1:0] fail_addr_o,
  output logic [2:0]        fail_elem_o,
  output logic [DATA_W-1:0] fail_data_o,
  output logic [ADDR_W-1:0] ram_a_o,
  output logic [DATA_W-1:0] ram_din_o,
  output logic              ram_wr_o,
  output logic              ram_oe_o,
  output logic              ram_test_mode_o,
  input  logic [DATA_W-1:0] ram_dout_i
);

  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;
  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [2:0]        ELEM_LAST = 3'd5;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FLUSH, ST_DONE} state_t;

  state_t              state_q;
  logic [2:0]          elem_q;
  logic [ADDR_W-1:0]   addr_q;
  logic                op_q;
  logic                busy_q, done_q, fail_q;
  logic [ADDR_W-1:0]   fail_addr_q;
  logic [2:0]          fail_elem_q;
  logic [DATA_W-1:0]   fail_data_q;
  logic [ADDR_W-1:0]   ram_a_q;
  logic [DATA_W-1:0]   ram_din_q;
  logic                ram_wr_q, ram_oe_q;
  logic                cmp_valid_q;
  logic [DATA_W-1:0]   cmp_exp_q;
  logic [ADDR_W-1:0]   cmp_addr_q;
  logic [2:0]          cmp_elem_q;

  // Element shape: E3/E4 walk downwards, E1..E4 have a read then a write per address.
  function automatic logic elem_down(input logic [2:0] e);
    return (e == 3'd3) || (e == 3'd4);
  endfunction

  function automatic logic elem_two_ops(input logic [2:0] e);
    return (e >= 3'd1) && (e <= 3'd4);
  endfunction

  // Background select: the read of E2/E4 expects "1", writes of E1/E3 store "1".
  function automatic logic [DATA_W-1:0] rd_pattern(input logic [2:0] e);
    return ((e == 3'd2) || (e == 3'd4)) ? ~BG_DATA : BG_DATA;
  endfunction

  function automatic logic [DATA_W-1:0] wr_pattern(input logic [2:0] e);
    return ((e == 3'd1) || (e == 3'd3)) ? ~BG_DATA : BG_DATA;
  endfunction

  logic                last_in_addr, addr_term, last_op, mismatch;
  logic [2:0]          nxt_elem, iss_elem;
  logic [ADDR_W-1:0]   nxt_addr, iss_addr;
  logic                nxt_op, iss_op, iss_rd;
  logic [DATA_W-1:0]   iss_din;

  assign last_in_addr = elem_two_ops(elem_q) ? op_q : 1'b1;
  assign addr_term    = elem_down(elem_q) ? (addr_q == '0) : (addr_q == ADDR_MAX);
  assign last_op      = last_in_addr && addr_term && (elem_q == ELEM_LAST);
  assign mismatch     = cmp_valid_q && (ram_dout_i != cmp_exp_q);

  // Step the sequencer position to the op that follows the one currently on the port.
  always_comb begin
    nxt_elem = elem_q;
    nxt_addr = addr_q;
    nxt_op   = 1'b0;
    if (!last_in_addr) begin
      nxt_op = 1'b1;
    end else if (addr_term) begin
      nxt_elem = elem_q + 3'd1;
      nxt_addr = elem_down(nxt_elem) ? ADDR_MAX : '0;
    end else if (elem_down(elem_q)) begin
      nxt_addr = addr_q - ADDR_ONE;
    end else begin
      nxt_addr = addr_q + ADDR_ONE;
    end
  end

  // Op to put on the port at the coming edge: the first op on start, else the next one.
  always_comb begin
    iss_elem = 3'd0;
    iss_addr = '0;
    iss_op   = 1'b0;
    if (state_q == ST_RUN) begin
      iss_elem = nxt_elem;
      iss_addr = nxt_addr;
      iss_op   = nxt_op;
    end
    iss_rd  = (iss_elem != 3'd0) && !iss_op;
    iss_din = iss_rd ? '0 : wr_pattern(iss_elem);
  end

  // Sequencer FSM with registered RAM port, compare pipeline and failure capture.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= ST_IDLE;
      elem_q      <= 3'd0;
      addr_q      <= '0;
      op_q        <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      fail_q      <= 1'b0;
      fail_addr_q <= '0;
      fail_elem_q <= 3'd0;
      fail_data_q <= '0;
      ram_a_q     <= '0;
      ram_din_q   <= '0;
      ram_wr_q    <= 1'b0;
      ram_oe_q    <= 1'b0;
      cmp_valid_q <= 1'b0;
      cmp_exp_q   <= '0;
      cmp_addr_q  <= '0;
      cmp_elem_q  <= 3'd0;
    end else begin
      // The op on the port this cycle is described by elem_q; its read data returns next cycle.
      cmp_valid_q <= ram_oe_q;
      cmp_exp_q   <= rd_pattern(elem_q);
      cmp_addr_q  <= ram_a_q;
      cmp_elem_q  <= elem_q;

      if (mismatch && !fail_q) begin
        fail_q      <= 1'b1;
        fail_addr_q <= cmp_addr_q;
        fail_elem_q <= cmp_elem_q;
        fail_data_q <= ram_dout_i;
      end

      case (state_q)
        ST_IDLE, ST_DONE: begin
          ram_wr_q <= 1'b0;
          ram_oe_q <= 1'b0;
          if (start_i) begin
            state_q     <= ST_RUN;
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
            fail_q      <= 1'b0;
            fail_addr_q <= '0;
            fail_elem_q <= 3'd0;
            fail_data_q <= '0;
            elem_q      <= iss_elem;
            addr_q      <= iss_addr;
            op_q        <= iss_op;
            ram_a_q     <= iss_addr;
            ram_din_q   <= iss_din;
            ram_wr_q    <= !iss_rd;
            ram_oe_q    <= iss_rd;
          end
        end
        ST_RUN: begin
`ifdef BIST_STOP_ON_FAIL_EN
          if (mismatch) begin
            // Abort: the op issued this cycle is never compared.
            state_q     <= ST_DONE;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
            ram_wr_q    <= 1'b0;
            ram_oe_q    <= 1'b0;
            cmp_valid_q <= 1'b0;
          end else
`endif
          if (last_op) begin
            state_q  <= ST_FLUSH;
            ram_wr_q <= 1'b0;
            ram_oe_q <= 1'b0;
          end else begin
            elem_q    <= iss_elem;
            addr_q    <= iss_addr;
            op_q      <= iss_op;
            ram_a_q   <= iss_addr;
            ram_din_q <= iss_din;
            ram_wr_q  <= !iss_rd;
            ram_oe_q  <= iss_rd;
          end
        end
        ST_FLUSH: begin
          state_q  <= ST_DONE;
          busy_q   <= 1'b0;
          done_q   <= 1'b1;
          ram_wr_q <= 1'b0;
          ram_oe_q <= 1'b0;
        end
        default: begin
          state_q  <= ST_IDLE;
          busy_q   <= 1'b0;
          ram_wr_q <= 1'b0;
          ram_oe_q <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o          = busy_q;
  assign done_o          = done_q;
  assign fail_o          = fail_q;
  assign fail_addr_o     = fail_addr_q;
  assign fail_elem_o     = fail_elem_q;
  assign fail_data_o     = fail_data_q;
  assign ram_a_o         = ram_a_q;
  assign ram_din_o       = ram_din_q;
  assign ram_wr_o        = ram_wr_q;
  assign ram_oe_o        = ram_oe_q;
  // The array is always tested directly, never through the bypass path.
  assign ram_test_mode_o = 1'b0;

endmodule

// File: tb/tb_ram_128x16_bist_ctrl.sv
// Testbench for ram_128x16_bist_ctrl: RAM model with injectable faults and an op-trace scoreboard.
module tb_ram_128x16_bist_ctrl;

  logic        clk = 1'b0;
  logic        reset_i = 1'b1;
  logic        start_i = 1'b0;
  logic        busy_o, done_o, fail_o;
  logic [6:0]  fail_addr_o;
  logic [2:0]  fail_elem_o;
  logic [15:0] fail_data_o;
  logic [6:0]  ram_a_o;
  logic [15:0] ram_din_o;
  logic        ram_wr_o, ram_oe_o, ram_test_mode_o;
  logic [15:0] ram_dout_i = 16'h0000;

  ram_128x16_bist_ctrl dut (
    .clk_i(clk), .reset_i(reset_i), .start_i(start_i),
    .busy_o(busy_o), .done_o(done_o), .fail_o(fail_o),
    .fail_addr_o(fail_addr_o), .fail_elem_o(fail_elem_o), .fail_data_o(fail_data_o),
    .ram_a_o(ram_a_o), .ram_din_o(ram_din_o), .ram_wr_o(ram_wr_o), .ram_oe_o(ram_oe_o),
    .ram_test_mode_o(ram_test_mode_o), .ram_dout_i(ram_dout_i)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM model: 0 = good, 1 = bit 3 stuck-at-1 at addr 5, 2 = write to 0x10 inverts 0x11.
  int          fault_mode = 0;
  logic [15:0] mem [128];
  initial for (int i = 0; i < 128; i++) mem[i] = 16'h0000;

  always @(posedge clk) begin
    if (ram_wr_o) begin
      mem[ram_a_o] <= ram_din_o;
      if (fault_mode == 2 && ram_a_o == 7'h10) mem[7'h11] <= ~mem[7'h11];
    end
    if (ram_oe_o)
      ram_dout_i <= (fault_mode == 1 && ram_a_o == 7'h05) ? (mem[ram_a_o] | 16'h0008) : mem[ram_a_o];
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  // Scoreboard entries: {wr, oe, addr, write data (0 on reads)}.
  logic [24:0] exp_q[$];

  task automatic push_trace();
    for (int e = 0; e < 6; e++) begin
      for (int s = 0; s < 128; s++) begin
        logic [6:0]  a;
        logic [15:0] wd;
        a  = (e == 3 || e == 4) ? 7'(127 - s) : 7'(s);
        wd = (e == 1 || e == 3) ? 16'hFFFF : 16'h0000;
        if (e != 0) exp_q.push_back({1'b0, 1'b1, a, 16'h0000});
        if (e != 5) exp_q.push_back({1'b1, 1'b0, a, wd});
      end
    end
  endtask

  // Monitor, sampling on the falling edge; rel = 1 is the cycle right after the start edge.
  bit          mon_en = 1'b0;
  bit          sb_en  = 1'b1;
  int          start_cyc = 0;
  int          rel, busy_cnt, first_busy, last_busy, done_rel, wr_cnt, oe_cnt, op_idx;
  logic [6:0]  trace_a [1280];
  logic [24:0] got_op;

  always @(negedge clk) begin
    if (mon_en) begin
      rel = cyc - start_cyc + 1;
      if (busy_o) begin
        busy_cnt++;
        last_busy = rel;
        if (first_busy == 0) first_busy = rel;
      end
      if (done_o && done_rel == 0) done_rel = rel;
      if (ram_wr_o) wr_cnt++;
      if (ram_oe_o) oe_cnt++;
      if (ram_wr_o || ram_oe_o) begin
        if (op_idx < 1280) trace_a[op_idx] = ram_a_o;
        op_idx++;
        if (sb_en) begin
          got_op = {ram_wr_o, ram_oe_o, ram_a_o, ram_wr_o ? ram_din_o : 16'h0000};
          if (exp_q.size() == 0) check("op_extra", 64'(got_op), 64'd0);
          else check($sformatf("op%0d", op_idx - 1), 64'(got_op), 64'(exp_q.pop_front()));
        end
      end
    end
  end

  task automatic reset_stats();
    mon_en = 1'b0;
    busy_cnt = 0; first_busy = 0; last_busy = 0; done_rel = 0;
    wr_cnt = 0; oe_cnt = 0; op_idx = 0;
  endtask

  task automatic do_start(input bit hold);
    @(posedge clk);
    #2 start_i = 1'b1;
    @(posedge clk);
    #1;
    start_cyc = cyc;
    mon_en    = 1'b1;
    if (!hold) start_i = 1'b0;
  endtask

  task automatic wait_done(input int max_cyc);
    int n = 0;
    while (!done_o && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    #1;
    check("done_seen", 64'(done_o), 64'd1);
  endtask

  task automatic full_checks();
    check("done_rel", 64'(done_rel), 64'd1282);
    check("first_busy", 64'(first_busy), 64'd1);
    check("last_busy", 64'(last_busy), 64'd1281);
    check("busy_cnt", 64'(busy_cnt), 64'd1281);
    check("wr_cnt", 64'(wr_cnt), 64'd640);
    check("oe_cnt", 64'(oe_cnt), 64'd640);
    check("sb_left", 64'(exp_q.size()), 64'd0);
    check("e3_first_a", 64'(trace_a[640]), 64'd127);
    check("e3_last_a", 64'(trace_a[895]), 64'd0);
    check("e4_last_a", 64'(trace_a[1151]), 64'd0);
    check("e5_first_a", 64'(trace_a[1152]), 64'd0);
  endtask

  // One complete run; fail_idx is the op index of the expected first failing read.
  task automatic run_full(input int fault, input bit exp_fail, input logic [6:0] exp_addr,
                          input logic [2:0] exp_elem, input logic [15:0] exp_data, input int fail_idx);
    fault_mode = fault;
    exp_q.delete();
    push_trace();
    reset_stats();
    do_start(1'b0);
    wait_done(1400);
    check("fail", 64'(fail_o), 64'(exp_fail));
    if (exp_fail) begin
      check("fail_addr", 64'(fail_addr_o), 64'(exp_addr));
      check("fail_elem", 64'(fail_elem_o), 64'(exp_elem));
      check("fail_data", 64'(fail_data_o), 64'(exp_data));
    end
`ifdef BIST_STOP_ON_FAIL_EN
    if (exp_fail) check("stop_done_rel", 64'(done_rel), 64'(fail_idx + 3));
    else full_checks();
`else
    full_checks();
`endif
    check("busy_after", 64'(busy_o), 64'd0);
    $display("run fault=%0d fail=%0b addr=%0h elem=%0d data=%0h done_rel=%0d",
             fault, fail_o, fail_addr_o, fail_elem_o, fail_data_o, done_rel);
    exp_q.delete();
  endtask

  initial begin
    int exp_rel;
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_done", 64'(done_o), 64'd0);
    check("rst_fail", 64'(fail_o), 64'd0);
    check("rst_fail_info", 64'({fail_addr_o, fail_elem_o, fail_data_o}), 64'd0);
    check("rst_port", 64'({ram_a_o, ram_din_o, ram_wr_o, ram_oe_o, ram_test_mode_o}), 64'd0);
    reset_i = 1'b0;

    // Good RAM, stuck-at bit, coupling fault
    run_full(0, 1'b0, 7'h00, 3'd0, 16'h0000, 0);
    run_full(1, 1'b1, 7'h05, 3'd1, 16'h0008, 128 + 2 * 5);
    run_full(2, 1'b1, 7'h11, 3'd1, 16'hFFFF, 128 + 2 * 17);

    // Reset in the middle of a run, then a fresh full run
    fault_mode = 0;
    push_trace();
    reset_stats();
    do_start(1'b0);
    repeat (499) @(negedge clk);
    reset_i = 1'b1;
    mon_en  = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_busy", 64'(busy_o), 64'd0);
    check("midrst_wr_oe", 64'({ram_wr_o, ram_oe_o}), 64'd0);
    check("midrst_done", 64'(done_o), 64'd0);
    @(posedge clk);
    #1;
    check("midrst_hold", 64'({busy_o, ram_wr_o, ram_oe_o}), 64'd0);
    reset_i = 1'b0;
    $display("reset abort at rel=%0d busy=%0b", rel, busy_o);
    run_full(0, 1'b0, 7'h00, 3'd0, 16'h0000, 0);

    // start held high across a faulty run: restart on the first DONE cycle
    sb_en = 1'b0;
    fault_mode = 1;
    reset_stats();
    do_start(1'b1);
    wait_done(1400);
`ifdef BIST_STOP_ON_FAIL_EN
    exp_rel = 128 + 2 * 5 + 3;
`else
    exp_rel = 1282;
`endif
    check("hold_done_rel", 64'(done_rel), 64'(exp_rel));
    check("hold_fail1", 64'(fail_o), 64'd1);
    @(posedge clk);
    #1;
    check("hold_restart_busy", 64'(busy_o), 64'd1);
    check("hold_restart_done", 64'(done_o), 64'd0);
    check("hold_restart_fail", 64'({fail_o, fail_addr_o, fail_elem_o, fail_data_o}), 64'd0);
    check("hold_test_mode", 64'(ram_test_mode_o), 64'd0);
    start_i = 1'b0;
    wait_done(1400);
    check("hold_fail2", 64'(fail_o), 64'd1);
    check("hold_fail2_addr", 64'(fail_addr_o), 64'd5);
    $display("hold run done_rel=%0d fail=%0b", done_rel, fail_o);
    sb_en = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Absolute guard against a hung run.
  initial begin
    #2000000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
